// File: rtl/alu_mem_unit_if.sv
// Bus bundle for alu_mem_unit: ALU operand/result signals and the single-port memory access.
// The master side drives operands and memory requests; the slave side returns results and read data.
interface alu_mem_unit_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [2:0]            alu_opcode;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero_flag;
    logic                  alu_overflow_flag;

    modport master (
        output mem_we, mem_addr, mem_data_in, alu_a, alu_b, alu_opcode,
        input  mem_data_out, alu_result, alu_zero_flag, alu_overflow_flag
    );

    modport slave (
        input  mem_we, mem_addr, mem_data_in, alu_a, alu_b, alu_opcode,
        output mem_data_out, alu_result, alu_zero_flag, alu_overflow_flag
    );
endinterface

// File: rtl/alu_mem_unit.sv
// Combinational ADD/AND/NOT ALU alongside a word memory with asynchronous read,
// synchronous write and an asynchronous reset that clears every word.
module alu_mem_unit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    alu_mem_unit_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned MSB   = DATA_WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_AND = 3'b001,
        OP_NOT = 3'b010
    } alu_op_e;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] result;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign sum = bus.alu_a + bus.alu_b;

    // ALU: unsupported opcodes yield zero with no overflow
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_op_e'(bus.alu_opcode))
            OP_ADD: begin
                result   = sum;
                overflow = (bus.alu_a[MSB] == bus.alu_b[MSB]) && (sum[MSB] != bus.alu_a[MSB]);
            end
            OP_AND:  result = bus.alu_a & bus.alu_b;
            OP_NOT:  result = ~bus.alu_a;
            default: result = '0;
        endcase
    end

    assign bus.alu_result        = result;
    assign bus.alu_zero_flag     = (result == '0);
    assign bus.alu_overflow_flag = overflow;

    // Memory array: reset clears all words without waiting for a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_WIDTH'(i)] <= '0;
            end
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_data_in;
        end
    end

    assign bus.mem_data_out = mem[bus.mem_addr];
endmodule

// File: tb/tb_alu_mem_unit.sv
// Self-checking bench for alu_mem_unit: directed and randomized ALU vectors against an
// arithmetic reference, and memory traffic against an array model.
module tb_alu_mem_unit;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [DW-1:0] model_mem [256];

    alu_mem_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    alu_mem_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU from signed/unsigned integer arithmetic
    function automatic void ref_alu(input int unsigned a, input int unsigned b, input int unsigned op,
                                    output int unsigned r, output bit z, output bit o);
        int sa, sb, ssum;
        r = 0;
        o = 1'b0;
        if (op == 0) begin
            r    = (a + b) % 256;
            sa   = (a > 127) ? int'(a) - 256 : int'(a);
            sb   = (b > 127) ? int'(b) - 256 : int'(b);
            ssum = sa + sb;
            o    = (ssum > 127) || (ssum < -128);
        end else if (op == 1) begin
            r = a & b;
        end else if (op == 2) begin
            r = 255 - a;
        end
        z = (r == 0);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
    endtask

    task automatic test_reset();
        int unsigned addrs [4];
        addrs[0] = 0; addrs[1] = 8'h10; addrs[2] = 8'hFF; addrs[3] = $urandom_range(1, 254);
        #3;
        for (int i = 0; i < 4; i++) begin
            bus.mem_addr = AW'(addrs[i]);
            #1;
            n_cmp++;
            if (bus.mem_data_out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_read addr=%02h got=%02h exp=00", addrs[i], bus.mem_data_out);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_alu_directed();
        int unsigned op [9] = '{0, 0, 0, 0, 2, 2, 5, 7, 0};
        int unsigned a  [9] = '{8'h05, 8'h7F, 8'hFF, 8'hF0, 8'hFF, 8'h0F, 8'h12, 8'hAA, 8'h80};
        int unsigned b  [9] = '{8'h03, 8'h01, 8'h01, 8'h0F, 8'h3C, 8'h99, 8'h34, 8'h55, 8'h80};
        int unsigned er [9] = '{8'h08, 8'h80, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00};
        bit          ez [9] = '{0, 0, 1, 1, 1, 0, 1, 1, 1};
        bit          eo [9] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
        op[3] = 1;
        for (int i = 0; i < 9; i++) begin
            bus.alu_opcode = 3'(op[i]);
            bus.alu_a      = DW'(a[i]);
            bus.alu_b      = DW'(b[i]);
            #1;
            n_cmp++;
            if ({bus.alu_result, bus.alu_zero_flag, bus.alu_overflow_flag} !== {DW'(er[i]), ez[i], eo[i]}) begin
                n_fail++;
                $display("FAIL alu_directed[%0d] op=%0d a=%02h b=%02h got r=%02h z=%b o=%b exp r=%02h z=%b o=%b",
                         i, op[i], a[i], b[i], bus.alu_result, bus.alu_zero_flag, bus.alu_overflow_flag,
                         er[i], ez[i], eo[i]);
            end
        end
    endtask

    task automatic test_alu_random(input string tag, input int n);
        int unsigned a, b, op, r;
        bit z, o;
        for (int i = 0; i < n; i++) begin
            a  = $urandom_range(0, 255);
            b  = $urandom_range(0, 255);
            op = $urandom_range(0, 7);
            bus.alu_a = DW'(a); bus.alu_b = DW'(b); bus.alu_opcode = 3'(op);
            #1;
            ref_alu(a, b, op, r, z, o);
            n_cmp++;
            if ({bus.alu_result, bus.alu_zero_flag, bus.alu_overflow_flag} !== {DW'(r), z, o}) begin
                n_fail++;
                $display("FAIL %s op=%0d a=%02h b=%02h got r=%02h z=%b o=%b exp r=%02h z=%b o=%b",
                         tag, op, a, b, bus.alu_result, bus.alu_zero_flag, bus.alu_overflow_flag, r, z, o);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.mem_we = 1'b1; bus.mem_addr = 8'h10; bus.mem_data_in = 8'hA5;
        #1;
        n_cmp++;
        if (bus.mem_data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL write_before_edge got=%02h exp=00", bus.mem_data_out);
        end
        @(posedge clk);
        #1;
        model_mem[8'h10] = 8'hA5;
        n_cmp++;
        if (bus.mem_data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_after_edge got=%02h exp=a5", bus.mem_data_out);
        end
        @(negedge clk);
        bus.mem_we = 1'b0; bus.mem_addr = 8'h11;
        #1;
        n_cmp++;
        if (bus.mem_data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL neighbour_addr11 got=%02h exp=00", bus.mem_data_out);
        end
    endtask

    task automatic test_we_low();
        @(negedge clk);
        bus.mem_we = 1'b0; bus.mem_addr = 8'h10; bus.mem_data_in = 8'h33;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.mem_data_out !== model_mem[8'h10]) begin
            n_fail++;
            $display("FAIL we_low_hold got=%02h exp=%02h", bus.mem_data_out, model_mem[8'h10]);
        end
    endtask

    task automatic test_boundary();
        int unsigned addrs [2] = '{8'h00, 8'hFF};
        int unsigned datas [2] = '{8'h01, 8'h02};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.mem_we = 1'b1; bus.mem_addr = AW'(addrs[i]); bus.mem_data_in = DW'(datas[i]);
            @(posedge clk);
            model_mem[addrs[i]] = DW'(datas[i]);
        end
        @(negedge clk);
        bus.mem_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.mem_addr = AW'(addrs[i]);
            #1;
            n_cmp++;
            if (bus.mem_data_out !== DW'(datas[i])) begin
                n_fail++;
                $display("FAIL boundary addr=%02h got=%02h exp=%02h", addrs[i], bus.mem_data_out, datas[i]);
            end
        end
    endtask

    task automatic test_mem_random(input int n);
        int unsigned addr, data;
        bit we;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            we   = ($urandom_range(0, 2) != 0);
            addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) * 85 : $urandom_range(0, 255);
            data = $urandom_range(0, 255);
            bus.mem_we = we; bus.mem_addr = AW'(addr); bus.mem_data_in = DW'(data);
            #1;
            n_cmp++;
            if (bus.mem_data_out !== model_mem[addr]) begin
                n_fail++;
                $display("FAIL mem_rand_pre[%0d] addr=%02h got=%02h exp=%02h", i, addr, bus.mem_data_out, model_mem[addr]);
            end
            @(posedge clk);
            if (we) model_mem[addr] = DW'(data);
            #1;
            n_cmp++;
            if (bus.mem_data_out !== model_mem[addr]) begin
                n_fail++;
                $display("FAIL mem_rand_post[%0d] addr=%02h got=%02h exp=%02h", i, addr, bus.mem_data_out, model_mem[addr]);
            end
        end
        @(negedge clk);
        bus.mem_we = 1'b0;
    endtask

    task automatic test_async_reset();
        int bad = 0;
        @(negedge clk);
        bus.mem_we = 1'b1; bus.mem_addr = 8'hFF; bus.mem_data_in = 8'h5A;
        @(posedge clk);
        model_mem[8'hFF] = 8'h5A;
        @(negedge clk);
        bus.mem_we = 1'b0;
        #1;
        n_cmp++;
        if (bus.mem_data_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL pre_reset_ff got=%02h exp=5a", bus.mem_data_out);
        end
        #1;
        reset = 1'b1;
        clear_model();
        #1;
        n_cmp++;
        if (bus.mem_data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL async_clear_ff got=%02h exp=00", bus.mem_data_out);
        end
        for (int i = 0; i < 256; i++) begin
            bus.mem_addr = AW'(i);
            #0.01;
            if (bus.mem_data_out !== 8'h00) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL async_clear_all nonzero_words=%0d exp=0", bad);
        end
        @(negedge clk);
        bus.mem_we = 1'b1; bus.mem_addr = 8'hFF; bus.mem_data_in = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.mem_data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL write_during_reset got=%02h exp=00", bus.mem_data_out);
        end
        test_alu_random("alu_in_reset", 20);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_data_in = 8'hC3;
        @(posedge clk);
        model_mem[8'hFF] = 8'hC3;
        #1;
        n_cmp++;
        if (bus.mem_data_out !== 8'hC3) begin
            n_fail++;
            $display("FAIL first_write_after_reset got=%02h exp=c3", bus.mem_data_out);
        end
        @(negedge clk);
        bus.mem_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        int unsigned base, data [4];
        base = $urandom_range(0, 250);
        for (int i = 0; i < 4; i++) begin
            data[i] = $urandom_range(0, 255);
            @(negedge clk);
            bus.mem_we = 1'b1; bus.mem_addr = AW'(base + i); bus.mem_data_in = DW'(data[i]);
            @(posedge clk);
            model_mem[base + i] = DW'(data[i]);
        end
        @(negedge clk);
        bus.mem_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_addr = AW'(base + i);
            #1;
            n_cmp++;
            if (bus.mem_data_out !== model_mem[base + i]) begin
                n_fail++;
                $display("FAIL back_to_back addr=%02h got=%02h exp=%02h", base + i, bus.mem_data_out, model_mem[base + i]);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_data_in = '0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_opcode = '0;
        test_reset();
        test_alu_directed();
        test_alu_random("alu_rand", 200);
        test_write_read();
        test_we_low();
        test_boundary();
        test_mem_random(60);
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
